alu_arb2: RTL and testbench

Two-port arbiter that shares one `alu32` instance between two requesters, typically the execute stage (port 0) and the branch/address unit (port 1). It accepts one operation per cycle through per-port valid/ready request channels and selects between them by round-robin or fixed priority. It evaluates the selected operation on the shared ALU and returns the result through a registered, per-port response slot with its own valid/ready handshake.

---
 rtl/core_pkg.sv | 30 +++
 rtl/alu_arb2_if.sv | 31 +++
 rtl/alu32.sv | 70 +++++++
 rtl/rr_arb2.sv | 44 ++++
 rtl/alu_arb2.sv | 124 ++++++++++++
 tb/tb_alu_arb2.sv | 341 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the ALU and the two-port ALU arbiter.
//   Xlen       : datapath width
//   NumAluReq  : number of requesters sharing the ALU
//   aluop_e    : ALU operation class (Add, Sleft, Branch, Funct)
//   alu_req_t  : one ALU request (op class, funct3/funct7, I-type flag, operands)
// -----------------------------------------------------------------------------
package core_pkg;

   localparam int Xlen      = 32;
   localparam int NumAluReq = 2;

   typedef enum logic [1:0] {
      Add    = 2'd0,
      Sleft  = 2'd1,
      Branch = 2'd2,
      Funct  = 2'd3
   } aluop_e;

   typedef struct packed {
      aluop_e            aluop;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic              itype;
      logic [Xlen-1:0]   a;
      logic [Xlen-1:0]   b;
   } alu_req_t;

endpackage

// File: rtl/alu_arb2_if.sv
// -----------------------------------------------------------------------------
// alu_arb2_if
// Request/response bundle between the requesters and alu_arb2.
//   req_valid / req_ready : per-port request handshake
//   req                   : per-port request payload (alu_req_t)
//   rsp_valid / rsp_ready : per-port response slot handshake
//   rsp_res / rsp_zero    : per-port result and branch-taken flag
// Modports: master = requester/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface alu_arb2_if;
   import core_pkg::*;

   logic     [NumAluReq-1:0]            req_valid;
   logic     [NumAluReq-1:0]            req_ready;
   alu_req_t [NumAluReq-1:0]            req;
   logic     [NumAluReq-1:0]            rsp_valid;
   logic     [NumAluReq-1:0]            rsp_ready;
   logic     [NumAluReq-1:0][Xlen-1:0]  rsp_res;
   logic     [NumAluReq-1:0]            rsp_zero;

   modport master (
      output req_valid, req, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_zero
   );

   modport slave (
      input  req_valid, req, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_zero
   );

endinterface

// File: rtl/alu32.sv
// -----------------------------------------------------------------------------
// alu32
// Purely combinational RV32-style ALU.
//   aluop  in  op class: Add (a+b), Sleft (a<<b[4:0]), Branch (compare), Funct
//   funct3 in  operation select for Funct / condition select for Branch
//   funct7 in  0x20 selects SUB (R-type only) and SRA
//   itype  in  I-type flag (immediate forms have no SUB)
//   a, b   in  operands
//   res    out result (a-b for Branch)
//   zero   out Branch: condition taken; otherwise res == 0
// -----------------------------------------------------------------------------
module alu32
   import core_pkg::*;
(
   input  aluop_e          aluop,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic            itype,
   input  logic [Xlen-1:0] a,
   input  logic [Xlen-1:0] b,
   output logic [Xlen-1:0] res,
   output logic            zero
);

   logic       alt;
   logic [4:0] shamt;

   assign alt   = (funct7 == 7'h20);
   assign shamt = b[4:0];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // (an unassigned path in always_comb would infer a latch).
      res  = '0;
      zero = 1'b0;
      unique case (aluop)
         Add:   res = a + b;
         Sleft: res = a << shamt;
         Branch: begin
            res = a - b;
            unique case (funct3)
               3'd0:    zero = (a == b);
               3'd1:    zero = (a != b);
               3'd4:    zero = ($signed(a) <  $signed(b));
               3'd5:    zero = ($signed(a) >= $signed(b));
               3'd6:    zero = (a <  b);
               3'd7:    zero = (a >= b);
               default: zero = (res == '0);
            endcase
         end
         Funct: begin
            unique case (funct3)
               3'd0: res = (alt && !itype) ? a - b : a + b;
               3'd1: res = a << shamt;
               3'd2: res = {{(Xlen-1){1'b0}}, ($signed(a) < $signed(b))};
               3'd3: res = {{(Xlen-1){1'b0}}, (a < b)};
               3'd4: res = a ^ b;
               3'd5: res = alt ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
               3'd6: res = a | b;
               3'd7: res = a & b;
            endcase
         end
         default: res = '0;
      endcase
      if (aluop != Branch) begin
         zero = (res == '0);
      end
   end

endmodule

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way arbiter, round-robin or fixed priority (port 0 wins).
//   FixedPrio  param  0: round-robin, 1: port 0 always wins a conflict
//   clk_i      in     clock
//   rst_ni     in     asynchronous active-low reset
//   elig       in     per-port eligibility
//   hs         in     a handshake completes this cycle (grant is taken)
//   gnt        out    one-hot grant (zero when nothing is eligible)
// last_grant resets to 1 so the first conflict after reset goes to port 0.
// -----------------------------------------------------------------------------
module rr_arb2 #(
   parameter bit FixedPrio = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] elig,
   input  logic       hs,
   output logic [1:0] gnt
);

   logic last_grant;  // index of the port that completed the last handshake

   always_comb begin
      gnt = 2'b00;
      unique case (elig)
         2'b01: gnt = 2'b01;
         2'b10: gnt = 2'b10;
         2'b11: gnt = (FixedPrio || last_grant) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of process ordering.
      if (!rst_ni) begin
         last_grant <= 1'b1;
      end else if (hs) begin
         last_grant <= gnt[1];
      end
   end

endmodule

// File: rtl/alu_arb2.sv
// -----------------------------------------------------------------------------
// alu_arb2
// Shares one alu32 between two requesters. One request is accepted per cycle;
// the result lands in a registered per-port response slot one cycle later.
//   FixedPrio    param  0: round-robin, 1: port 0 always wins a conflict
//   clk_i        in     clock
//   rst_ni       in     asynchronous active-low reset (clears all slots)
//   bus          slave  request/response bundle (alu_arb2_if)
//   stall_cnt_o  out    32-bit saturating count of cycles with any valid
//                       request left unaccepted; present only when the
//                       macro ALU_ARB_STALL_CNT_EN is defined
// A port is eligible when it is valid and its slot is empty or popping this
// cycle. Branch results are forced to 0 (only the taken flag is returned) and
// the taken flag is forced to 0 for every non-branch op and for branch
// funct3 2/3, which are not branch conditions.
// -----------------------------------------------------------------------------
module alu_arb2
   import core_pkg::*;
#(
   parameter bit FixedPrio = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
`ifdef ALU_ARB_STALL_CNT_EN
   output logic [31:0] stall_cnt_o,
`endif
   alu_arb2_if.slave   bus
);

   logic [NumAluReq-1:0]           slot_free;
   logic [NumAluReq-1:0]           elig;
   logic [NumAluReq-1:0]           gnt;
   logic [NumAluReq-1:0]           hs;
   logic                           fire;
   alu_req_t                       sel;
   logic [Xlen-1:0]                alu_res;
   logic                           alu_zero;
   logic [Xlen-1:0]                san_res;
   logic                           san_zero;
   logic [NumAluReq-1:0]           rsp_valid_q;
   logic [NumAluReq-1:0][Xlen-1:0] rsp_res_q;
   logic [NumAluReq-1:0]           rsp_zero_q;

   // Slot may be refilled in the same cycle it is popped.
   assign slot_free = ~rsp_valid_q | bus.rsp_ready;
   assign elig      = bus.req_valid & slot_free;

   rr_arb2 #(
      .FixedPrio (FixedPrio)
   ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .elig   (elig),
      .hs     (fire),
      .gnt    (gnt)
   );

   // Ready depends only on valid, slot state and arbiter history, never on
   // operands; held low while in reset.
   assign bus.req_ready = gnt & {NumAluReq{rst_ni}};
   assign hs            = bus.req_valid & bus.req_ready;
   assign fire          = |hs;

   assign sel = gnt[1] ? bus.req[1] : bus.req[0];

   alu32 u_alu (
      .aluop  (sel.aluop),
      .funct3 (sel.funct3),
      .funct7 (sel.funct7),
      .itype  (sel.itype),
      .a      (sel.a),
      .b      (sel.b),
      .res    (alu_res),
      .zero   (alu_zero)
   );

   always_comb begin
      san_res  = alu_res;
      san_zero = 1'b0;
      if (sel.aluop == Branch) begin
         san_res  = '0;
         san_zero = (sel.funct3[2:1] == 2'b01) ? 1'b0 : alu_zero;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the slot data registers are reset along with the valid bits
         // so the outputs are defined (never X) straight out of reset.
         rsp_valid_q <= '0;
         rsp_res_q   <= '0;
         rsp_zero_q  <= '0;
      end else begin
         for (int r = 0; r < NumAluReq; r++) begin
            if (hs[r]) begin
               rsp_valid_q[r] <= 1'b1;
               rsp_res_q[r]   <= san_res;
               rsp_zero_q[r]  <= san_zero;
            end else if (bus.rsp_ready[r]) begin
               rsp_valid_q[r] <= 1'b0;
            end
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_zero  = rsp_zero_q;

`ifdef ALU_ARB_STALL_CNT_EN
   logic stall;

   assign stall = |(bus.req_valid & ~bus.req_ready);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_o <= '0;
      end else if (stall && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arb2.sv
// -----------------------------------------------------------------------------
// tb_alu_arb2
// Self-checking bench for alu_arb2. A reference model of arbitration, slot
// state and the ALU pushes expected responses into per-port queues when a
// request is accepted; they are popped and compared when the slot is read.
// A second instance with FixedPrio=1 covers fixed priority and, when
// ALU_ARB_STALL_CNT_EN is defined, the stall counter.
// -----------------------------------------------------------------------------
module tb_alu_arb2;
   import core_pkg::*;

   typedef struct packed {
      logic [Xlen-1:0] res;
      logic            zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   alu_arb2_if bus ();
   alu_arb2_if bus_fp ();

`ifdef ALU_ARB_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] stall_cnt_fp;
`endif

   alu_arb2 #(.FixedPrio(1'b0)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
`ifdef ALU_ARB_STALL_CNT_EN
      .stall_cnt_o (stall_cnt),
`endif
      .bus         (bus)
   );

   alu_arb2 #(.FixedPrio(1'b1)) u_dut_fp (
      .clk_i       (clk),
      .rst_ni      (rst_n),
`ifdef ALU_ARB_STALL_CNT_EN
      .stall_cnt_o (stall_cnt_fp),
`endif
      .bus         (bus_fp)
   );

   int         n_chk = 0;
   int         n_bad = 0;

   // reference model state
   logic       m_last;
   logic [1:0] m_valid;
   logic [1:0] m_gnt;
   int         m_stall;
   exp_t       sb0[$];
   exp_t       sb1[$];
   logic [1:0] obs_ready;
   logic [1:0] keep;

   logic [31:0] ba [6];
   logic [31:0] bb [6];
   logic [2:0]  bf [6];
   logic        bz [6];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
      end
   endtask

   function automatic alu_req_t mk(input aluop_e op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic it, input logic [31:0] a, input logic [31:0] b);
      alu_req_t q;
      q.aluop  = op;
      q.funct3 = f3;
      q.funct7 = f7;
      q.itype  = it;
      q.a      = a;
      q.b      = b;
      return q;
   endfunction

   function automatic alu_req_t rnd_req();
      alu_req_t   q;
      logic [1:0] op2;
      op2      = 2'($urandom_range(0, 3));
      q.aluop  = aluop_e'(op2);
      q.funct3 = 3'($urandom_range(0, 7));
      q.funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      q.itype  = 1'($urandom_range(0, 1));
      q.a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      q.b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      return q;
   endfunction

   // Expected slot contents for a request, including output sanitising.
   function automatic exp_t model_alu(input alu_req_t q);
      exp_t       e;
      logic [4:0] sh;
      e.res  = '0;
      e.zero = 1'b0;
      sh     = q.b[4:0];
      case (q.aluop)
         Add:   e.res = q.a + q.b;
         Sleft: e.res = q.a << sh;
         Branch: begin
            case (q.funct3)
               3'd0:    e.zero = (q.a == q.b);
               3'd1:    e.zero = (q.a != q.b);
               3'd4:    e.zero = ($signed(q.a) < $signed(q.b));
               3'd5:    e.zero = !($signed(q.a) < $signed(q.b));
               3'd6:    e.zero = (q.a < q.b);
               3'd7:    e.zero = !(q.a < q.b);
               default: e.zero = 1'b0;
            endcase
         end
         default: begin
            case (q.funct3)
               3'd0: e.res = (q.funct7 == 7'h20 && !q.itype) ? q.a - q.b : q.a + q.b;
               3'd1: e.res = q.a << sh;
               3'd2: e.res = ($signed(q.a) < $signed(q.b)) ? 32'd1 : 32'd0;
               3'd3: e.res = (q.a < q.b) ? 32'd1 : 32'd0;
               3'd4: e.res = q.a ^ q.b;
               3'd5: e.res = (q.funct7 == 7'h20) ? 32'($signed(q.a) >>> sh) : q.a >> sh;
               3'd6: e.res = q.a | q.b;
               default: e.res = q.a & q.b;
            endcase
         end
      endcase
      return e;
   endfunction

   // Called at the negative edge: compare outputs, then advance the model
   // to what the next rising edge will do.
   task automatic evaluate();
      exp_t       e;
      logic [1:0] elig;
      for (int r = 0; r < 2; r++) begin
         check($sformatf("rsp_valid[%0d]", r), bus.rsp_valid[r], m_valid[r]);
         if (m_valid[r] && ((r == 0) ? sb0.size() : sb1.size()) != 0) begin
            e = (r == 0) ? sb0[0] : sb1[0];
            check($sformatf("rsp_res[%0d]", r), bus.rsp_res[r], e.res);
            check($sformatf("rsp_zero[%0d]", r), bus.rsp_zero[r], e.zero);
            if (bus.rsp_ready[r]) begin
               if (r == 0) void'(sb0.pop_front());
               else        void'(sb1.pop_front());
            end
         end
      end
      elig = bus.req_valid & (~m_valid | bus.rsp_ready);
      case (elig)
         2'b01:   m_gnt = 2'b01;
         2'b10:   m_gnt = 2'b10;
         2'b11:   m_gnt = m_last ? 2'b01 : 2'b10;
         default: m_gnt = 2'b00;
      endcase
      obs_ready = bus.req_ready;
      check("req_ready", bus.req_ready, m_gnt);
      if (m_gnt[0]) begin
         sb0.push_back(model_alu(bus.req[0]));
         m_last = 1'b0;
      end
      if (m_gnt[1]) begin
         sb1.push_back(model_alu(bus.req[1]));
         m_last = 1'b1;
      end
      if (|(bus.req_valid & ~m_gnt)) m_stall++;
      m_valid = m_gnt | (m_valid & ~bus.rsp_ready);
   endtask

   task automatic cycle();
      @(negedge clk);
      evaluate();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      ba = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd1};
      bb = '{32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'hFFFF_FFFF};
      bf = '{3'd4, 3'd6, 3'd2, 3'd2, 3'd0, 3'd5};
      bz = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      rst_n            = 1'b0;
      bus.req_valid    = 2'b11;
      bus.req          = '0;
      bus.rsp_ready    = 2'b11;
      bus_fp.req_valid = 2'b00;
      bus_fp.req       = '0;
      bus_fp.rsp_ready = 2'b11;
      m_last           = 1'b1;
      m_valid          = 2'b00;
      m_gnt            = 2'b00;
      m_stall          = 0;
      keep             = 2'b00;

      // reset state (ready forced low even with both ports valid)
      #12;
      check("rst_rsp_valid", bus.rsp_valid, 2'b00);
      check("rst_rsp_res0", bus.rsp_res[0], 32'd0);
      check("rst_rsp_res1", bus.rsp_res[1], 32'd0);
      check("rst_rsp_zero", bus.rsp_zero, 2'b00);
      check("rst_req_ready", bus.req_ready, 2'b00);
      bus.req_valid = 2'b00;
      rst_n         = 1'b1;
      @(posedge clk);
      #1;

      // round-robin conflict: 0,1,0,1
      bus.req[0] = mk(Add, 3'd0, 7'h00, 1'b0, 32'd10, 32'd1);
      bus.req[1] = mk(Funct, 3'd0, 7'h20, 1'b0, 32'd3, 32'd5);
      bus.req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check($sformatf("rr_seq%0d", i), obs_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (m_gnt[0]) bus.req[0] = mk(Add, 3'd0, 7'h00, 1'b0, 32'(10 * (i + 2)), 32'd1);
      end
      check("rr_sub_res", bus.rsp_res[1], 32'hFFFF_FFFE);
      bus.req_valid = 2'b00;
      cycle();

      // single port, 5+7
      bus.req[0]    = mk(Funct, 3'd0, 7'h00, 1'b0, 32'd5, 32'd7);
      bus.req_valid = 2'b01;
      cycle();
      check("add_ready", obs_ready, 2'b01);
      bus.req_valid = 2'b00;
      check("add_valid", bus.rsp_valid[0], 1'b1);
      check("add_res", bus.rsp_res[0], 32'd12);
      check("add_zero", bus.rsp_zero[0], 1'b0);
      cycle();

      // full slot 0 blocks only port 0; then pop and refill together
      bus.rsp_ready = 2'b10;
      bus.req[0]    = mk(Add, 3'd0, 7'h00, 1'b0, 32'd100, 32'd1);
      bus.req_valid = 2'b01;
      cycle();
      bus.req[0]    = mk(Add, 3'd0, 7'h00, 1'b0, 32'd200, 32'd2);
      bus.req[1]    = mk(Sleft, 3'd0, 7'h00, 1'b0, 32'd1, 32'd4);
      bus.req_valid = 2'b11;
      cycle();
      check("blocked_ready", obs_ready, 2'b10);
      bus.req_valid = 2'b01;
      bus.rsp_ready = 2'b11;
      cycle();
      check("pop_refill_ready", obs_ready, 2'b01);
      check("pop_refill_res", bus.rsp_res[0], 32'd202);
      bus.req_valid = 2'b00;
      cycle();

      // branch sanitising on port 1, back-to-back
      bus.req_valid = 2'b10;
      for (int i = 0; i < 6; i++) begin
         bus.req[1] = mk(Branch, bf[i], 7'h00, 1'b0, ba[i], bb[i]);
         cycle();
         check($sformatf("br_zero%0d", i), bus.rsp_zero[1], bz[i]);
         check($sformatf("br_res%0d", i), bus.rsp_res[1], 32'd0);
      end
      bus.req_valid = 2'b00;
      cycle();

      // random traffic obeying the requester rules
      for (int i = 0; i < 60; i++) begin
         for (int r = 0; r < 2; r++) begin
            if (!keep[r]) begin
               bus.req_valid[r] = 1'($urandom_range(0, 1));
               bus.req[r]       = rnd_req();
            end
            bus.rsp_ready[r] = ($urandom_range(0, 3) != 0);
         end
         cycle();
         keep = bus.req_valid & ~m_gnt;
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b11;
      cycle();
      cycle();

      // asynchronous reset with slot 1 full
      bus.req[1]    = mk(Add, 3'd0, 7'h00, 1'b0, 32'd7, 32'd8);
      bus.req_valid = 2'b10;
      bus.rsp_ready = 2'b00;
      cycle();
      bus.req_valid = 2'b00;
      cycle();
      bus.req[0]    = mk(Add, 3'd0, 7'h00, 1'b0, 32'd1, 32'd1);
      bus.req[1]    = mk(Add, 3'd0, 7'h00, 1'b0, 32'd2, 32'd2);
      bus.req_valid = 2'b11;
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", bus.rsp_valid, 2'b00);
      check("async_rst_res1", bus.rsp_res[1], 32'd0);
      check("async_rst_ready", bus.req_ready, 2'b00);
      m_valid = 2'b00;
      m_last  = 1'b1;
      m_stall = 0;
      sb0.delete();
      sb1.delete();
      #1;
      rst_n         = 1'b1;
      bus.rsp_ready = 2'b11;
      cycle();
      check("post_rst_prio", obs_ready, 2'b01);
      bus.req_valid = 2'b10;
      cycle();
      bus.req_valid = 2'b00;
      cycle();

      // fixed-priority instance: port 1 never granted
      bus_fp.req[1]    = mk(Add, 3'd0, 7'h00, 1'b0, 32'd1, 32'd1);
      bus_fp.req_valid = 2'b11;
      for (int i = 0; i < 10; i++) begin
         bus_fp.req[0] = mk(Add, 3'd0, 7'h00, 1'b0, 32'(i), 32'd100);
         @(negedge clk);
         check($sformatf("fp_ready%0d", i), bus_fp.req_ready, 2'b01);
         check($sformatf("fp_valid1_%0d", i), bus_fp.rsp_valid[1], 1'b0);
         if (i > 0) check($sformatf("fp_res%0d", i), bus_fp.rsp_res[0], 32'(i - 1 + 100));
         @(posedge clk);
         #1;
      end
      bus_fp.req_valid = 2'b00;
`ifdef ALU_ARB_STALL_CNT_EN
      check("fp_stall_cnt", stall_cnt_fp, 32'd10);
      check("stall_cnt", stall_cnt, 32'(m_stall));
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
